// File: rtl/pipe_hold_ctrl.sv
// Pipeline hold/flush controller: arbitrates mem_wait, MDU stalls, taken branches and load-use.
// Optional MDU watchdog enabled by defining PIPE_HOLD_CTRL_WDOG_EN.
module pipe_hold_ctrl #(
  parameter int unsigned MDU_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_use,
  input  logic       branch_taken,
  input  logic       mdu_start,
  input  logic       mdu_done,
  input  logic       mem_wait,
  output logic [2:0] hold_if,
  output logic [2:0] hold_id,
  output logic [2:0] hold_ex,
  output logic [2:0] hold_mem,
  output logic       redirect,
  output logic       timeout_err
);

  localparam logic [2:0] H_PASS  = 3'b000;
  localparam logic [2:0] H_FLUSH = 3'b001;
  localparam logic [2:0] H_HOLD  = 3'b010;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MDU_BUSY = 2'd1,
    BR_PEND  = 2'd2
  } state_t;

  state_t state;
  logic   mdu_active;
  logic   br_flush;
  logic   wdog_fire;

  assign mdu_active = ((state == IDLE) && mdu_start) || (state == MDU_BUSY);
  assign br_flush   = (state == BR_PEND) || ((state == IDLE) && branch_taken);

`ifdef PIPE_HOLD_CTRL_WDOG_EN
  localparam logic [7:0] WDOG_LAST = 8'(MDU_TIMEOUT - 1);

  logic [7:0] wdog_cnt;
  logic       err_q;

  // Counter freezes under mem_wait so the state-hold rule also holds the watchdog.
  assign wdog_fire = (state == MDU_BUSY) && !mdu_done && !mem_wait && (wdog_cnt == WDOG_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdog_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state != MDU_BUSY)
        wdog_cnt <= '0;
      else if (!mem_wait)
        wdog_cnt <= wdog_cnt + 8'd1;
      if (wdog_fire)
        err_q <= 1'b1;
    end
  end

  assign timeout_err = err_q;
`else
  assign wdog_fire   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else if (mem_wait) begin
      // A branch resolved during a bus stall is remembered and flushed once the bus frees.
      if ((state == IDLE) && branch_taken && !mdu_start)
        state <= BR_PEND;
    end else begin
      unique case (state)
        IDLE:     if (mdu_start && !mdu_done) state <= MDU_BUSY;
        MDU_BUSY: if (mdu_done || wdog_fire) state <= IDLE;
        BR_PEND:  state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

  always_comb begin
    hold_if  = H_PASS;
    hold_id  = H_PASS;
    hold_ex  = H_PASS;
    hold_mem = H_PASS;
    redirect = 1'b0;
    if (!rst) begin
      hold_if = H_PASS;
    end else if (mem_wait) begin
      hold_if  = H_HOLD;
      hold_id  = H_HOLD;
      hold_ex  = H_HOLD;
      hold_mem = H_HOLD;
    end else if (wdog_fire) begin
      hold_ex = H_FLUSH;
    end else if (mdu_active) begin
      if (!mdu_done) begin
        hold_if  = H_HOLD;
        hold_id  = H_HOLD;
        hold_ex  = H_HOLD;
        hold_mem = H_FLUSH;
      end
    end else if (br_flush) begin
      hold_if  = H_FLUSH;
      hold_id  = H_FLUSH;
      redirect = 1'b1;
    end else if (load_use) begin
      hold_if = H_HOLD;
      hold_id = H_HOLD;
      hold_ex = H_FLUSH;
    end
  end

endmodule

// File: tb/tb_pipe_hold_ctrl.sv
// Directed, table-driven bench for pipe_hold_ctrl; watchdog checks follow PIPE_HOLD_CTRL_WDOG_EN.
module tb_pipe_hold_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       load_use = 1'b0, branch_taken = 1'b0, mdu_start = 1'b0, mdu_done = 1'b0, mem_wait = 1'b0;
  logic [2:0] hold_if, hold_id, hold_ex, hold_mem;
  logic       redirect, timeout_err;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  pipe_hold_ctrl #(.MDU_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .load_use(load_use), .branch_taken(branch_taken),
    .mdu_start(mdu_start), .mdu_done(mdu_done), .mem_wait(mem_wait),
    .hold_if(hold_if), .hold_id(hold_id), .hold_ex(hold_ex), .hold_mem(hold_mem),
    .redirect(redirect), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // in = {load_use, branch_taken, mdu_start, mdu_done, mem_wait}
  // exp = {hold_if, hold_id, hold_ex, hold_mem, redirect, timeout_err}
  typedef struct {
    logic [4:0]  in;
    logic [13:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [4:0] in, input logic [2:0] hi, input logic [2:0] hd,
                              input logic [2:0] he, input logic [2:0] hm, input logic rd);
    vec_t v;
    v.in  = in;
    v.exp = {hi, hd, he, hm, rd, 1'b0};
    return v;
  endfunction

  function automatic logic [13:0] outs();
    return {hold_if, hold_id, hold_ex, hold_mem, redirect, timeout_err};
  endfunction

  task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got if=%b id=%b ex=%b mem=%b redir=%b err=%b, want if=%b id=%b ex=%b mem=%b redir=%b err=%b",
               name, act[13:11], act[10:8], act[7:5], act[4:2], act[1], act[0],
               exp[13:11], exp[10:8], exp[7:5], exp[4:2], exp[1], exp[0]);
    end
  endtask

  // Drive a cycle's inputs just after the rising edge, then sample mid-cycle.
  task automatic drive(input logic [4:0] in);
    @(posedge clk);
    #1 {load_use, branch_taken, mdu_start, mdu_done, mem_wait} = in;
    #5;
  endtask

  localparam logic [2:0] P = 3'b000, F = 3'b001, H = 3'b010;
  localparam logic [13:0] ALL_PASS = 14'b0;

  initial begin
    // idle
    vecs.push_back(mk(5'b00000, P, P, P, P, 1'b0));
    // MDU start at cycle 0, done at cycle 5
    vecs.push_back(mk(5'b00100, H, H, H, F, 1'b0));
    vecs.push_back(mk(5'b00000, H, H, H, F, 1'b0));
    vecs.push_back(mk(5'b00000, H, H, H, F, 1'b0));
    vecs.push_back(mk(5'b00000, H, H, H, F, 1'b0));
    vecs.push_back(mk(5'b00000, H, H, H, F, 1'b0));
    vecs.push_back(mk(5'b00010, P, P, P, P, 1'b0));
    vecs.push_back(mk(5'b00000, P, P, P, P, 1'b0));
    // single-cycle MDU op: no stall, stays idle
    vecs.push_back(mk(5'b00110, P, P, P, P, 1'b0));
    vecs.push_back(mk(5'b00000, P, P, P, P, 1'b0));
    // branch under mem_wait for 3 cycles, then flush + redirect
    vecs.push_back(mk(5'b01001, H, H, H, H, 1'b0));
    vecs.push_back(mk(5'b01001, H, H, H, H, 1'b0));
    vecs.push_back(mk(5'b01001, H, H, H, H, 1'b0));
    vecs.push_back(mk(5'b00000, F, F, P, P, 1'b1));
    vecs.push_back(mk(5'b00000, P, P, P, P, 1'b0));
    // load_use with branch: branch wins, load_use ignored
    vecs.push_back(mk(5'b11000, F, F, P, P, 1'b1));
    // load_use alone, then branch alone
    vecs.push_back(mk(5'b10000, H, H, F, P, 1'b0));
    vecs.push_back(mk(5'b01000, F, F, P, P, 1'b1));
    vecs.push_back(mk(5'b00000, P, P, P, P, 1'b0));
    // mem_wait alone
    vecs.push_back(mk(5'b00001, H, H, H, H, 1'b0));
    // mem_wait inside an MDU stall; done after bus frees
    vecs.push_back(mk(5'b00100, H, H, H, F, 1'b0));
    vecs.push_back(mk(5'b00001, H, H, H, H, 1'b0));
    vecs.push_back(mk(5'b00000, H, H, H, F, 1'b0));
    vecs.push_back(mk(5'b00010, P, P, P, P, 1'b0));
    // mdu_start during mem_wait from idle does not enter busy
    vecs.push_back(mk(5'b00101, H, H, H, H, 1'b0));
    vecs.push_back(mk(5'b00000, P, P, P, P, 1'b0));
    // MDU stall outranks load_use
    vecs.push_back(mk(5'b10100, H, H, H, F, 1'b0));
    vecs.push_back(mk(5'b10000, H, H, H, F, 1'b0));
    vecs.push_back(mk(5'b00010, P, P, P, P, 1'b0));
    vecs.push_back(mk(5'b00000, P, P, P, P, 1'b0));

    // outputs held at pass while in reset, even with stall inputs present
    #2 {load_use, branch_taken, mdu_start, mdu_done, mem_wait} = 5'b11101;
    #6 check("in_reset", outs(), ALL_PASS);
    {load_use, branch_taken, mdu_start, mdu_done, mem_wait} = 5'b00000;
    #4 rst = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].in);
      check($sformatf("vec[%0d]", i), outs(), vecs[i].exp);
    end

    // reset pulsed in cycle 2 of an MDU stall
    drive(5'b00100);
    drive(5'b00000);
    drive(5'b00000);
    check("rst_pre_stall", outs(), {H, H, H, F, 1'b0, 1'b0});
    rst = 1'b0;
    #1 check("rst_immediate", outs(), ALL_PASS);
    @(posedge clk);
    #3 rst = 1'b1;
    #2 check("rst_release_idle", outs(), ALL_PASS);
    drive(5'b00000);
    check("rst_release_idle2", outs(), ALL_PASS);

    // reset discards a branch pending behind mem_wait
    drive(5'b01001);
    check("br_pend_wait", outs(), {H, H, H, H, 1'b0, 1'b0});
    rst = 1'b0;
    @(posedge clk);
    #3 rst = 1'b1;
    {load_use, branch_taken, mdu_start, mdu_done, mem_wait} = 5'b00000;
    #2 check("br_pend_discard", outs(), ALL_PASS);

`ifdef PIPE_HOLD_CTRL_WDOG_EN
    // MDU_TIMEOUT=8, no done: 8 stall cycles, then hold_ex flush, then sticky error
    drive(5'b00100);
    check("wd_stall0", outs(), {H, H, H, F, 1'b0, 1'b0});
    for (int k = 1; k < 8; k++) begin
      drive(5'b00000);
      check($sformatf("wd_stall%0d", k), outs(), {H, H, H, F, 1'b0, 1'b0});
    end
    drive(5'b00000);
    check("wd_fire", outs(), {P, P, F, P, 1'b0, 1'b0});
    drive(5'b00000);
    check("wd_err_set", outs(), {P, P, P, P, 1'b0, 1'b1});
    drive(5'b01000);
    check("wd_err_sticky", outs(), {F, F, P, P, 1'b1, 1'b1});
    rst = 1'b0;
    #1 check("wd_err_reset", outs(), ALL_PASS);
    @(posedge clk);
    #3 rst = 1'b1;
    {load_use, branch_taken, mdu_start, mdu_done, mem_wait} = 5'b00000;
`else
    // without the watchdog a long stall simply persists until done
    drive(5'b00100);
    for (int k = 1; k < 12; k++) drive(5'b00000);
    check("long_stall", outs(), {H, H, H, F, 1'b0, 1'b0});
    drive(5'b00010);
    check("long_stall_done", outs(), ALL_PASS);
`endif

    #20;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish, got running, want finished");
    $fatal(1);
  end

endmodule

// File: doc/pipe_hold_ctrl.md
PIPE_HOLD_CTRL -- requirements
Module: pipe_hold_ctrl

Interface
REQ-001 SHALL have parameter MDU_TIMEOUT, default 64, meaning the MDU watchdog limit in cycles (range 2..255).
REQ-002 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port load_use, input, 1 bit: load-use hazard detected in ID.
REQ-005 SHALL have port branch_taken, input, 1 bit: branch or jump resolved taken in EX.
REQ-006 SHALL have port mdu_start, input, 1 bit: multi-cycle mul/div issued in EX.
REQ-007 SHALL have port mdu_done, input, 1 bit: MDU result valid this cycle.
REQ-008 SHALL have port mem_wait, input, 1 bit: data bus not ready in MEM.
REQ-009 SHALL have ports hold_if, hold_id, hold_ex and hold_mem, each output, 3 bits: hold flags for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers respectively.
REQ-010 SHALL have port redirect, output, 1 bit: PC redirect strobe to fetch.
REQ-011 SHALL have port timeout_err, output, 1 bit: sticky MDU watchdog error.

Function
REQ-012 SHALL use these hold encodings only: 3'b000 pass, 3'b001 flush to reset value, 3'b010 hold current data.
REQ-013 SHALL implement FSM states IDLE, MDU_BUSY and BR_PEND, all registered.
REQ-014 SHALL decode the hold outputs combinationally from the state and the current inputs, with no added latency.
REQ-015 SHALL apply this priority, highest first: mem_wait, then MDU active, then branch, then load_use.
REQ-016 SHALL, while mem_wait=1, drive all four holds to 010 and leave the FSM state unchanged.
REQ-017 SHALL treat the MDU as active when (IDLE and mdu_start=1) or when the state is MDU_BUSY.
REQ-018 SHALL, while the MDU is active and mdu_done=0, drive hold_if, hold_id and hold_ex to 010 and hold_mem to 001.
REQ-019 SHALL go IDLE->MDU_BUSY on mdu_start=1 with mdu_done=0 and mem_wait=0; mdu_start with mdu_done in the same cycle is a single-cycle operation and causes no stall.
REQ-020 SHALL go MDU_BUSY->IDLE on mdu_done=1, and the holds SHALL read 000 in that done cycle.
REQ-021 SHALL, when the state is IDLE and branch_taken=1 with no higher-priority condition, drive hold_if and hold_id to 001 and pulse redirect=1 for one cycle.
REQ-022 SHALL latch branch_taken into BR_PEND when it arrives while mem_wait=1.
REQ-023 SHALL, in BR_PEND with mem_wait=0, apply the branch flush and redirect, then return to IDLE.
REQ-024 SHALL, on load_use=1 alone, drive hold_if and hold_id to 010 and hold_ex to 001 for that cycle only.
REQ-025 SHALL ignore load_use in any cycle that carries a branch flush.
REQ-026 SHALL drive redirect high only in a cycle where hold_if=001.

Reset
REQ-027 SHALL, while rst=0, set the state to IDLE and clear the watchdog counter and timeout_err, independent of clk.
REQ-028 SHALL drive all hold outputs to 000 and redirect to 0 while rst=0.
REQ-029 SHALL, on rst asserted mid-stall, discard any pending branch and release the stall on the first cycle after deassertion.

Configuration
REQ-030 SHALL, with macro PIPE_HOLD_CTRL_WDOG_EN defined, count cycles in MDU_BUSY using an 8-bit counter.
REQ-031 SHALL, with PIPE_HOLD_CTRL_WDOG_EN defined and the count at MDU_TIMEOUT-1 with no mdu_done, force IDLE, set timeout_err=1 sticky until reset, and flush hold_ex to 001 for one cycle.
REQ-032 SHALL, with PIPE_HOLD_CTRL_WDOG_EN undefined, omit the counter, tie timeout_err to 0 and wait for mdu_done indefinitely.

Verification
REQ-033 SHALL cover: reset released, all inputs 0 -> all holds 000, redirect 0, timeout_err 0.
REQ-034 SHALL cover: mdu_start at cycle 0, mdu_done at cycle 5 -> hold_ex=010 and hold_mem=001 for cycles 0-4, all holds 000 at cycle 5.
REQ-035 SHALL cover: branch_taken together with mem_wait for 3 cycles -> holds all 010 for 3 cycles, then hold_if=hold_id=001 and redirect=1 in cycle 3.
REQ-036 SHALL cover: load_use and branch_taken in the same cycle -> hold_if=hold_id=001 and hold_ex=000.
REQ-037 SHALL cover: with PIPE_HOLD_CTRL_WDOG_EN, MDU_TIMEOUT=8 and no done -> stall lasts 8 cycles, then timeout_err=1 and hold_ex=001 for one cycle.
REQ-038 SHALL cover: rst pulsed low in cycle 2 of an MDU stall -> holds 000 immediately, state IDLE after release.
